// File: rtl/fish_event_ctrl_if.sv
// -----------------------------------------------------------------------------
// fish_event_ctrl_if
// Signal bundle between the gameflow side and the fishing event scheduler.
//   master : gameflow/button side; drives tick, gameflow state and buttons,
//            observes the event pulses, status flags and counters.
//   slave  : the scheduler itself (fish_event_ctrl).
// Signals:
//   tick                           game-time enable, one cycle wide
//   q_start_menu/q_base_play/
//   q_line_reel                    one-hot gameflow state
//   cast_line, reel_in             debounced one-cycle button pulses
//   fish_hooked, fish_caught_lost  one-cycle event pulses to gameflow
//   caught                         result of the last catch attempt
//   line_out, bite_alert           line in water / hookable bite active
//   reel_progress, fish_count      reel counter, landed-fish counter
//   count_down                     remaining game ticks
// -----------------------------------------------------------------------------
interface fish_event_ctrl_if;
    logic        tick;
    logic        q_start_menu;
    logic        q_base_play;
    logic        q_line_reel;
    logic        cast_line;
    logic        reel_in;
    logic        fish_hooked;
    logic        fish_caught_lost;
    logic        caught;
    logic        line_out;
    logic        bite_alert;
    logic [7:0]  reel_progress;
    logic [7:0]  fish_count;
    logic [15:0] count_down;

    modport master (
        output tick, q_start_menu, q_base_play, q_line_reel, cast_line, reel_in,
        input  fish_hooked, fish_caught_lost, caught, line_out, bite_alert,
               reel_progress, fish_count, count_down
    );

    modport slave (
        input  tick, q_start_menu, q_base_play, q_line_reel, cast_line, reel_in,
        output fish_hooked, fish_caught_lost, caught, line_out, bite_alert,
               reel_progress, fish_count, count_down
    );
endinterface

// File: rtl/fish_event_ctrl.sv
// -----------------------------------------------------------------------------
// fish_event_ctrl
// Runs the cast -> bite -> hook -> reel -> result sequence of the fishing game,
// emits the fish_hooked / fish_caught_lost pulses for the gameflow FSM, and
// owns the game countdown and the landed-fish counter. Bite delays are drawn
// from a free-running 16-bit Galois LFSR. Game time advances only on tick.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  fish_event_ctrl_if.slave (inputs: tick, gameflow state, buttons;
//        outputs: pulses, caught, line_out, bite_alert, counters)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module fish_event_ctrl #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          BITE_MIN    = 4,
    parameter int          HOOK_WIN    = 8,
    parameter int          REEL_TARGET = 12,
    parameter int          SLACK_MAX   = 6,
    parameter logic [15:0] GAME_TIME   = 16'd600
) (
    input  logic              clk,
    input  logic              rst,
    fish_event_ctrl_if.slave  bus
);

    localparam logic [7:0] BITE_MIN_C    = 8'(BITE_MIN);
    localparam logic [7:0] HOOK_WIN_C    = 8'(HOOK_WIN);
    localparam logic [7:0] REEL_TARGET_C = 8'(REEL_TARGET);
    localparam logic [7:0] SLACK_MAX_C   = 8'(SLACK_MAX);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BITE = 3'd1,
        S_BITE      = 3'd2,
        S_REEL      = 3'd3,
        S_RESULT    = 3'd4
    } state_t;

    // One step of x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_t      state_r, state_s;
    logic [15:0] lfsr_r;
    logic [7:0]  bite_cnt_r, bite_cnt_s;
    logic [7:0]  win_r, win_s;
    logic [7:0]  prog_r, prog_s;
    logic [7:0]  slack_r, slack_s;
    logic        caught_r, caught_s;
    logic        hook_s, result_s;
    logic        line_s, bite_s;
    logic        active_s;
    logic        fish_hooked_r, fish_caught_lost_r;
    logic        line_out_r, bite_alert_r;
    logic [7:0]  fish_count_r;
    logic [15:0] count_down_r;

    // Gameplay is live only in BASE_PLAY or LINE_REEL; otherwise the sequence aborts.
    assign active_s = bus.q_base_play | bus.q_line_reel;

    // Next-state, sequence counters and event pulses for the scheduler FSM.
    always_comb begin
        state_s    = state_r;
        bite_cnt_s = bite_cnt_r;
        win_s      = win_r;
        prog_s     = prog_r;
        slack_s    = slack_r;
        caught_s   = caught_r;
        hook_s     = 1'b0;
        result_s   = 1'b0;
        if (!active_s) begin
            // Quit/timeout: drop the sequence silently.
            state_s = S_IDLE;
            prog_s  = 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.q_base_play && bus.cast_line) begin
                        state_s    = S_WAIT_BITE;
                        bite_cnt_s = BITE_MIN_C + {4'd0, lfsr_r[3:0]};
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_WAIT_BITE: begin
                    if (bus.reel_in) begin
                        state_s = S_IDLE;
                    end else if (bus.tick) begin
                        bite_cnt_s = bite_cnt_r - 8'd1;
                        if (bite_cnt_r == 8'd1) begin
                            state_s = S_BITE;
                            win_s   = HOOK_WIN_C;
                        end else begin
                            state_s = S_WAIT_BITE;
                        end
                    end else begin
                        state_s = S_WAIT_BITE;
                    end
                end
                S_BITE: begin
                    // reel_in is checked first so a hook beats an expiring tick.
                    if (bus.reel_in) begin
                        state_s = S_REEL;
                        hook_s  = 1'b1;
                        prog_s  = 8'd0;
                        slack_s = 8'd0;
                    end else if (bus.tick) begin
                        win_s = win_r - 8'd1;
                        if (win_r == 8'd1) begin
                            state_s = S_IDLE;
                        end else begin
                            state_s = S_BITE;
                        end
                    end else begin
                        state_s = S_BITE;
                    end
                end
                S_REEL: begin
                    if (bus.reel_in) begin
                        prog_s  = prog_r + 8'd1;
                        slack_s = 8'd0;
                        if ((prog_r + 8'd1) == REEL_TARGET_C) begin
                            state_s  = S_RESULT;
                            caught_s = 1'b1;
                            result_s = 1'b1;
                        end else begin
                            state_s = S_REEL;
                        end
                    end else if (bus.tick) begin
                        slack_s = slack_r + 8'd1;
                        if ((slack_r + 8'd1) == SLACK_MAX_C) begin
                            state_s  = S_RESULT;
                            caught_s = 1'b0;
                            result_s = 1'b1;
                        end else begin
                            state_s = S_REEL;
                        end
                    end else begin
                        state_s = S_REEL;
                    end
                end
                S_RESULT: begin
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // Status flags are decoded from the next state so they register alongside it.
    always_comb begin
        line_s = 1'b0;
        bite_s = 1'b0;
        case (state_s)
            S_WAIT_BITE: line_s = 1'b1;
            S_BITE: begin
                line_s = 1'b1;
                bite_s = 1'b1;
            end
            S_REEL:      line_s = 1'b1;
            default: begin
                line_s = 1'b0;
                bite_s = 1'b0;
            end
        endcase
    end

    // FSM state, sequence counters and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= S_IDLE;
            bite_cnt_r         <= 8'd0;
            win_r              <= 8'd0;
            prog_r             <= 8'd0;
            slack_r            <= 8'd0;
            caught_r           <= 1'b0;
            fish_hooked_r      <= 1'b0;
            fish_caught_lost_r <= 1'b0;
            line_out_r         <= 1'b0;
            bite_alert_r       <= 1'b0;
        end else begin
            state_r            <= state_s;
            bite_cnt_r         <= bite_cnt_s;
            win_r              <= win_s;
            prog_r             <= prog_s;
            slack_r            <= slack_s;
            caught_r           <= caught_s;
            fish_hooked_r      <= hook_s;
            fish_caught_lost_r <= result_s;
            line_out_r         <= line_s;
            bite_alert_r       <= bite_s;
        end
    end

    // Free-running bite-delay LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Game countdown: reloads in the start menu, counts ticks during play, stops at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_down_r <= GAME_TIME;
        end else if (bus.q_start_menu) begin
            count_down_r <= GAME_TIME;
        end else if (active_s && bus.tick && (count_down_r != 16'd0)) begin
            count_down_r <= count_down_r - 16'd1;
        end else begin
            count_down_r <= count_down_r;
        end
    end

    // Landed-fish counter, bumped as the result is registered; saturates at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            fish_count_r <= 8'd0;
        end else if (bus.q_start_menu) begin
            fish_count_r <= 8'd0;
        end else if (result_s && caught_s && (fish_count_r != 8'hFF)) begin
            fish_count_r <= fish_count_r + 8'd1;
        end else begin
            fish_count_r <= fish_count_r;
        end
    end

    assign bus.fish_hooked      = fish_hooked_r;
    assign bus.fish_caught_lost = fish_caught_lost_r;
    assign bus.caught           = caught_r;
    assign bus.line_out         = line_out_r;
    assign bus.bite_alert       = bite_alert_r;
    assign bus.reel_progress    = prog_r;
    assign bus.fish_count       = fish_count_r;
    assign bus.count_down       = count_down_r;

endmodule
